// File: rtl/life_gen_sequencer.sv
// Generation controller for the Life core: button gestures (short/long press) drive
// single-step or free-run sequencing of compute -> wait for done -> copy.
module life_gen_sequencer #(
  parameter int TICK_DIV    = 25_000_000,
  parameter int DEBOUNCE    = 1_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             compute_done,
  input  logic             stable,
  output logic             load_seed,
  output logic             compute_start,
  output logic             copy_en,
  output logic             running,
  output logic             halted,
  output logic [GEN_W-1:0] gen_count
);

  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WAIT,
    COMPUTE,
    COPY
  } state_t;

  logic              sync_p0;
  logic              sync_p1;
  logic              db_level;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] press_cnt;
  logic              long_done;
  logic              short_evt;
  logic              long_evt;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic              pause_pend;
  logic              stable_q;

  // Stage p0/p1: two-flop synchroniser, then debounce and press-length classification.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      db_level  <= 1'b0;
      db_cnt    <= '0;
      press_cnt <= '0;
      long_done <= 1'b0;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
    end else begin
      sync_p0   <= button;
      sync_p1   <= sync_p0;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;

      if (sync_p1 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= sync_p1;
          db_cnt   <= '0;
          // A release only counts as a short press if the long event never fired.
          if (!sync_p1 && !long_done) begin
            short_evt <= 1'b1;
          end
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end

      if (!db_level) begin
        press_cnt <= '0;
        long_done <= 1'b0;
      end else if (!long_done) begin
        if (press_cnt == HOLD_LAST) begin
          long_evt  <= 1'b1;
          long_done <= 1'b1;
        end
        press_cnt <= press_cnt + 1'b1;
      end
    end
  end

  // Generation sequencer; pulses are registered so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      load_seed     <= 1'b0;
      compute_start <= 1'b0;
      copy_en       <= 1'b0;
      running       <= 1'b0;
      halted        <= 1'b0;
      gen_count     <= '0;
      tick_cnt      <= '0;
      pause_pend    <= 1'b0;
      stable_q      <= 1'b0;
    end else begin
      load_seed     <= 1'b0;
      compute_start <= 1'b0;
      copy_en       <= 1'b0;

      case (state)
        INIT: begin
          load_seed <= 1'b1;
          state     <= IDLE;
        end

        IDLE: begin
          if (short_evt) begin
            halted        <= 1'b0;
            compute_start <= 1'b1;
            state         <= COMPUTE;
          end else if (long_evt) begin
            halted   <= 1'b0;
            running  <= 1'b1;
            tick_cnt <= '0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (short_evt) begin
            running <= 1'b0;
            state   <= IDLE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt      <= '0;
            compute_start <= 1'b1;
            state         <= COMPUTE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        COMPUTE: begin
          if (short_evt && running) begin
            pause_pend <= 1'b1;
          end
          if (compute_done) begin
            stable_q <= stable;
            copy_en  <= 1'b1;
            state    <= COPY;
          end
        end

        COPY: begin
          gen_count <= gen_count + 1'b1;
          if (stable_q) begin
            halted     <= 1'b1;
            running    <= 1'b0;
            pause_pend <= 1'b0;
            state      <= IDLE;
          end else if (running && !pause_pend) begin
            tick_cnt <= '0;
            state    <= WAIT;
          end else begin
            running    <= 1'b0;
            pause_pend <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer: reset, debounce, step, free-run, pause, halt, abort.
module tb_life_gen_sequencer;

  localparam int TICK_DIV    = 8;
  localparam int DEBOUNCE    = 4;
  localparam int HOLD_CYCLES = 20;
  localparam int GEN_W       = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             button = 1'b0;
  logic             compute_done = 1'b0;
  logic             stable = 1'b0;
  logic             load_seed;
  logic             compute_start;
  logic             copy_en;
  logic             running;
  logic             halted;
  logic [GEN_W-1:0] gen_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_start = 0;
  int n_copy = 0;
  int n_load = 0;
  int last_start = -1;
  int prev_start = -1;
  int last_copy = -1;
  int dp_lat = 5;
  int dp_left = 0;
  bit dp_armed = 1'b0;
  bit stable_cfg = 1'b0;
  bit prev_any = 1'b0;

  always #5 clk = ~clk;

  life_gen_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .DEBOUNCE   (DEBOUNCE),
    .HOLD_CYCLES(HOLD_CYCLES),
    .GEN_W      (GEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .compute_done (compute_done),
    .stable       (stable),
    .load_seed    (load_seed),
    .compute_start(compute_start),
    .copy_en      (copy_en),
    .running      (running),
    .halted       (halted),
    .gen_count    (gen_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      $error("check %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: observe pulses, model the datapath done/stable response, check pulse exclusivity.
  task automatic step();
    int nh;
    @(posedge clk);
    #1;
    cyc++;
    compute_done = 1'b0;
    stable = 1'b0;
    if (load_seed === 1'b1) n_load++;
    if (copy_en === 1'b1) begin
      n_copy++;
      last_copy = cyc;
    end
    if (compute_start === 1'b1) begin
      n_start++;
      prev_start = last_start;
      last_start = cyc;
      dp_armed = 1'b1;
      dp_left = dp_lat;
    end
    if (rst) dp_armed = 1'b0;
    if (dp_armed) begin
      if (dp_left == 0) begin
        compute_done = 1'b1;
        stable = stable_cfg;
        dp_armed = 1'b0;
      end else begin
        dp_left--;
      end
    end
    nh = int'(load_seed === 1'b1) + int'(compute_start === 1'b1) + int'(copy_en === 1'b1);
    chk("pulse_exclusive", 32'((nh <= 1) && !(prev_any && nh > 0)), 32'd1);
    prev_any = (nh > 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int n);
    button = 1'b1;
    run(n);
    button = 1'b0;
  endtask

  task automatic wait_start(input int bound);
    int s0;
    s0 = n_start;
    for (int i = 0; i < bound; i++) begin
      step();
      if (n_start != s0) break;
    end
    chk("start_seen", 32'(n_start != s0), 32'd1);
  endtask

  task automatic wait_copy(input int bound);
    int c0;
    c0 = n_copy;
    for (int i = 0; i < bound; i++) begin
      step();
      if (n_copy != c0) break;
    end
    chk("copy_seen", 32'(n_copy != c0), 32'd1);
  endtask

  initial begin
    int rel;
    int s0;
    int c0;
    int l0;
    int gens;

    run(3);
    chk("rst_pulses", 32'({load_seed, compute_start, copy_en}), 32'd0);
    chk("rst_flags", 32'({running, halted}), 32'd0);
    chk("rst_gen", 32'(gen_count), 32'd0);

    rst = 1'b0;
    step();
    chk("seed_first", 32'(load_seed), 32'd1);
    step();
    chk("seed_one_cycle", 32'(load_seed), 32'd0);
    run(3);
    chk("seed_count", 32'(n_load), 32'd1);
    chk("init_running", 32'(running), 32'd0);
    chk("init_gen", 32'(gen_count), 32'd0);

    // Bounce: two 3-cycle glitches never pass the 4-cycle debounce.
    for (int g = 0; g < 2; g++) begin
      press(3);
      run(5);
    end
    run(40);
    chk("bounce_no_start", 32'(n_start), 32'd0);
    chk("bounce_running", 32'(running), 32'd0);

    // Short press: single step, done after 5 cycles.
    press(10);
    rel = cyc;
    wait_start(20);
    chk("step_latency", 32'(last_start - rel), 32'd7);
    wait_copy(20);
    chk("done_to_copy", 32'(last_copy - last_start), 32'd6);
    step();
    chk("step_gen", 32'(gen_count), 32'd1);
    chk("step_running", 32'(running), 32'd0);
    run(30);
    chk("step_idle", 32'(n_start), 32'd1);

    // Long press: free run; release must not pause.
    press(40);
    chk("long_running", 32'(running), 32'd1);
    run(20);
    chk("release_no_short", 32'(running), 32'd1);
    for (int i = 0; i < 400 && n_copy < 17; i++) step();
    chk("seventeen_gens", 32'(n_copy), 32'd17);
    chk("run_period", 32'(last_start - prev_start), 32'(TICK_DIV + 5 + 2));
    step();
    chk("gen_wrap", 32'(gen_count), 32'd1);

    // Short press during a long compute while running: copy still happens, then pause.
    dp_lat = 25;
    wait_start(40);
    press(10);
    run(3);
    chk("pend_running", 32'(running), 32'd1);
    wait_copy(40);
    chk("pause_copy_lat", 32'(last_copy - last_start), 32'd26);
    step();
    chk("pause_gen", 32'(gen_count), 32'd2);
    chk("pause_running", 32'(running), 32'd0);
    s0 = n_start;
    run(40);
    chk("paused_no_start", 32'(n_start - s0), 32'd0);

    // Still life while running: halt.
    dp_lat = 5;
    stable_cfg = 1'b1;
    s0 = n_start;
    press(30);
    wait_copy(60);
    step();
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_running", 32'(running), 32'd0);
    chk("halt_gen", 32'(gen_count), 32'd3);
    run(30);
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_one_gen", 32'(n_start - s0), 32'd1);

    // Stepping a halted board clears halted; a changed board stays unhalted.
    stable_cfg = 1'b0;
    press(10);
    wait_start(20);
    chk("step_clears_halt", 32'(halted), 32'd0);
    wait_copy(20);
    step();
    chk("unhalt_gen", 32'(gen_count), 32'd4);
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_running", 32'(running), 32'd0);

    // Stepping into a still life sets halted again.
    stable_cfg = 1'b1;
    press(10);
    wait_copy(40);
    step();
    chk("rehalt_flag", 32'(halted), 32'd1);
    chk("rehalt_gen", 32'(gen_count), 32'd5);

    // Reset during COMPUTE aborts the generation.
    stable_cfg = 1'b0;
    dp_lat = 25;
    press(10);
    wait_start(20);
    c0 = n_copy;
    l0 = n_load;
    run(3);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(30);
    gens = n_copy - c0;
    chk("abort_no_copy", 32'(gens), 32'd0);
    chk("abort_gen", 32'(gen_count), 32'd0);
    chk("abort_reseed", 32'(n_load - l0), 32'd1);
    chk("abort_flags", 32'({running, halted}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
